image_pixel_streamer: RTL

Downstream consumer of the image-transfer stage. On a start pulse it snapshots the full 28x28 8-bit image. It then streams the pixels in row-major order over a valid/ready interface to the first classifier layer (MAC array), tagging each pixel with its row, column and last flag. The snapshot decouples the classifier from later image-transfer writes.

---
 rtl/image_pixel_streamer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/image_pixel_streamer.sv
// image_pixel_streamer: snapshots a packed IMG_W x IMG_H 8-bit image on start
// and streams it row-major over valid/ready with row/col/last tags.
// Optional build macro: STREAM_ZERO_PAD_EN adds a one-pixel 0x00 border,
// giving an (IMG_H+2) x (IMG_W+2) frame.
module image_pixel_streamer #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned CW    = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [IMG_W*IMG_H-1:0][7:0]   image,
  output logic                          busy,
  output logic [7:0]                    pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [CW-1:0]                 pix_row,
  output logic [CW-1:0]                 pix_col,
  output logic                          pix_last,
  output logic                          done
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
`ifdef STREAM_ZERO_PAD_EN
  localparam int unsigned FW = IMG_W + 2;
  localparam int unsigned FH = IMG_H + 2;
`else
  localparam int unsigned FW = IMG_W;
  localparam int unsigned FH = IMG_H;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NPIX-1:0][7:0]    buf_q, buf_d;
  logic                    busy_q, busy_d;
  logic [7:0]              pix_data_q, pix_data_d;
  logic                    pix_valid_q, pix_valid_d;
  logic [CW-1:0]           pix_row_q, pix_row_d;
  logic [CW-1:0]           pix_col_q, pix_col_d;
  logic                    pix_last_q, pix_last_d;
  logic                    done_q, done_d;

  // Position bookkeeping: advanced coordinates and the pixel to present next
  logic                    col_wrap;
  logic [CW-1:0]           adv_row, adv_col;
  logic [CW-1:0]           sel_row, sel_col;
  logic                    sel_last;
  logic [7:0]              sel_pix;
  int unsigned             sel_idx;
  logic [AW-1:0]           sel_addr;
  logic                    sel_in_img;

  // Next coordinates after an accept, and the value of the pixel at sel_row/sel_col
  always_comb begin
    col_wrap = (pix_col_q == CW'(FW - 1));
    adv_col  = col_wrap ? '0 : pix_col_q + CW'(1);
    adv_row  = col_wrap ? pix_row_q + CW'(1) : pix_row_q;
    // First presentation after LOAD uses the current (0,0); later ones use the advanced position
    sel_row  = pix_valid_q ? adv_row : pix_row_q;
    sel_col  = pix_valid_q ? adv_col : pix_col_q;
    sel_last = (sel_row == CW'(FH - 1)) && (sel_col == CW'(FW - 1));
`ifdef STREAM_ZERO_PAD_EN
    sel_in_img = (sel_row != '0) && (sel_col != '0) &&
                 (sel_row != CW'(FH - 1)) && (sel_col != CW'(FW - 1));
    sel_idx    = sel_in_img ? (32'(sel_row) - 32'd1) * IMG_W + (32'(sel_col) - 32'd1) : 32'd0;
`else
    sel_in_img = 1'b1;
    sel_idx    = 32'(sel_row) * IMG_W + 32'(sel_col);
`endif
    sel_addr = AW'(sel_idx);
    sel_pix  = (sel_in_img && (sel_idx < NPIX)) ? buf_q[sel_addr] : 8'h00;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    pix_row_d   = pix_row_q;
    pix_col_d   = pix_col_q;
    pix_last_d  = pix_last_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        buf_d     = image;
        pix_row_d = '0;
        pix_col_d = '0;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (!pix_valid_q) begin
          // Present the first pixel of the freshly loaded snapshot
          pix_valid_d = 1'b1;
          pix_data_d  = sel_pix;
          pix_last_d  = sel_last;
        end else if (pix_ready) begin
          if (pix_last_q) begin
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            pix_row_d  = adv_row;
            pix_col_d  = adv_col;
            pix_data_d = sel_pix;
            pix_last_d = sel_last;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      pix_data_q  <= 8'h00;
      pix_valid_q <= 1'b0;
      pix_row_q   <= '0;
      pix_col_q   <= '0;
      pix_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_row_q   <= pix_row_d;
      pix_col_q   <= pix_col_d;
      pix_last_q  <= pix_last_d;
      done_q      <= done_d;
    end
  end

  // Snapshot buffer; intentionally not cleared by reset
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign busy      = busy_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign pix_row   = pix_row_q;
  assign pix_col   = pix_col_q;
  assign pix_last  = pix_last_q;
  assign done      = done_q;

endmodule
